// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Contents: controller state enum, register address map, CTRL bit layout,
// and the STATUS read-back payload.
package seg_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CTRL_W = 3;

  // Display source currently owning the peripheral
  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_DBG = 2'd1,
    ST_IRQ = 2'd2
  } seg_state_e;

  // Register map
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions; bit 2 is reserved and only stored
  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_DBG_EN = 1;

  localparam logic [CTRL_W-1:0] CTRL_RST = 3'b011;

  // STATUS read-back word
  typedef struct packed {
    logic [DATA_W-4:0] rsvd;
    seg_state_e        state;
    logic              irq_pending;
  } seg_status_t;

endpackage

// File: rtl/seg_scan_divider.sv
// Scan clock generator: divides clk so that scan_clk toggles once every
// SCAN_DIV cycles (period 2*SCAN_DIV).
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   scan_clk - divided scan clock (registered)
module seg_scan_divider #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic scan_clk
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_scan_clk;

  // Half-period counter; wrap and toggle on the terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_scan_clk <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt      <= '0;
      r_scan_clk <= ~r_scan_clk;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign scan_clk = r_scan_clk;

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: arbitrates the 16-bit display value
// between the CPU DATA register, a debug requester (valid/ready with a
// hold timer) and a sticky interrupt indication, and generates scan_clk.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   cpu_we/addr/... - CPU register port (DATA, CTRL, STATUS, reserved)
//   cpu_rdata       - combinational read data selected by cpu_addr
//   irq_in          - level interrupt source, rising edge latched
//   dbg_valid/data  - debug display offer
//   dbg_ready       - combinational accept for the debug offer
//   scan_clk        - divided scan clock
//   disp_data       - registered display value
//   disp_interrupt  - registered interrupt-pattern select
module seg_display_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        irq_in,
  input  logic        dbg_valid,
  input  logic [15:0] dbg_data,
  output logic        dbg_ready,
  output logic        scan_clk,
  output logic [15:0] disp_data,
  output logic        disp_interrupt
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_irq_pending;
  logic              r_irq_prev;
  seg_state_e        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DATA_W-1:0] r_dbg_val;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_int;

  seg_state_e        w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [DATA_W-1:0] w_dbg_val_nxt;
  logic [DATA_W-1:0] w_disp_data_nxt;
  logic              w_disp_int_nxt;
  logic              w_irq_rise;
  logic              w_irq_clr;
  logic              w_irq_pending_nxt;
  logic              w_dbg_ready;
  logic              w_dbg_xfer;
  seg_status_t       w_status;

  seg_scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div (
    .clk      (clk),
    .reset    (reset),
    .scan_clk (scan_clk)
  );

  // Interrupt latch: a qualified rising edge beats a same-cycle W1C clear
  assign w_irq_rise = irq_in & ~r_irq_prev & r_ctrl[CTRL_IRQ_EN];
  assign w_irq_clr  = cpu_we & (cpu_addr == ADDR_STATUS) & cpu_wdata[0];

  always_comb begin
    w_irq_pending_nxt = r_irq_pending;
    if (w_irq_clr) begin
      w_irq_pending_nxt = 1'b0;
    end
    if (w_irq_rise) begin
      w_irq_pending_nxt = 1'b1;
    end
  end

  // Debug handshake is refused whenever an interrupt is pending or shown
  assign w_dbg_ready = r_ctrl[CTRL_DBG_EN] & ~r_irq_pending & (r_state != ST_IRQ);
  assign w_dbg_xfer  = dbg_valid & w_dbg_ready;
  assign dbg_ready   = w_dbg_ready;

  // CPU-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data        <= '0;
      r_ctrl        <= CTRL_RST;
      r_irq_pending <= 1'b0;
      r_irq_prev    <= 1'b0;
    end else begin
      if (cpu_we && (cpu_addr == ADDR_DATA)) begin
        r_data <= cpu_wdata;
      end
      if (cpu_we && (cpu_addr == ADDR_CTRL)) begin
        r_ctrl <= cpu_wdata[CTRL_W-1:0];
      end
      r_irq_pending <= w_irq_pending_nxt;
      r_irq_prev    <= irq_in;
    end
  end

  // Read mux
  always_comb begin
    w_status             = '0;
    w_status.state       = r_state;
    w_status.irq_pending = r_irq_pending;
    cpu_rdata            = '0;
    case (cpu_addr)
      ADDR_DATA:   cpu_rdata = r_data;
      ADDR_CTRL:   cpu_rdata = DATA_W'(r_ctrl);
      ADDR_STATUS: cpu_rdata = w_status;
      ADDR_RSVD:   cpu_rdata = '0;
      default:     cpu_rdata = '0;
    endcase
  end

  // FSM state, hold timer, captured debug value and display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CPU;
      r_hold_cnt  <= '0;
      r_dbg_val   <= '0;
      r_disp_data <= '0;
      r_disp_int  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_dbg_val   <= w_dbg_val_nxt;
      r_disp_data <= w_disp_data_nxt;
      r_disp_int  <= w_disp_int_nxt;
    end
  end

  // Next-state and display selection, both from the pre-edge state
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold_cnt;
    w_dbg_val_nxt   = r_dbg_val;
    w_disp_data_nxt = r_disp_data;
    w_disp_int_nxt  = 1'b0;

    // IRQ keeps the last shown digits underneath the interrupt pattern
    case (r_state)
      ST_CPU:  w_disp_data_nxt = r_data;
      ST_DBG:  w_disp_data_nxt = r_dbg_val;
      ST_IRQ:  w_disp_int_nxt  = 1'b1;
      default: w_disp_int_nxt  = 1'b0;
    endcase

    if (r_irq_pending) begin
      w_state_nxt = ST_IRQ;
    end else begin
      case (r_state)
        ST_IRQ: begin
          // Any debug hold that was interrupted is dropped
          w_state_nxt = ST_CPU;
          w_hold_nxt  = '0;
        end
        ST_CPU: begin
          if (w_dbg_xfer) begin
            w_dbg_val_nxt = dbg_data;
            w_hold_nxt    = HOLD_LOAD;
            w_state_nxt   = ST_DBG;
          end
        end
        ST_DBG: begin
          if (!r_ctrl[CTRL_DBG_EN]) begin
            w_state_nxt = ST_CPU;
            w_hold_nxt  = '0;
          end else if (w_dbg_xfer) begin
            w_dbg_val_nxt = dbg_data;
            w_hold_nxt    = HOLD_LOAD;
          end else if (r_hold_cnt == '0) begin
            w_state_nxt = ST_CPU;
          end else begin
            w_hold_nxt = r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_CPU;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign disp_data      = r_disp_data;
  assign disp_interrupt = r_disp_int;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl with SCAN_DIV=4, HOLD_CYCLES=8.
module tb_seg_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [1:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        irq_in;
  logic        dbg_valid;
  logic [15:0] dbg_data;
  logic        dbg_ready;
  logic        scan_clk;
  logic [15:0] disp_data;
  logic        disp_interrupt;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .irq_in         (irq_in),
    .dbg_valid      (dbg_valid),
    .dbg_data       (dbg_data),
    .dbg_ready      (dbg_ready),
    .scan_clk       (scan_clk),
    .disp_data      (disp_data),
    .disp_interrupt (disp_interrupt)
  );

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model: mode 0 = CPU, 1 = debug shown, 2 = interrupt shown
  logic [15:0] m_data;
  logic [2:0]  m_ctrl;
  logic        m_pend;
  logic        m_prev;
  int          m_mode;
  int          m_remain;   // debug cycles still owed to the display
  logic [15:0] m_dbgv;
  logic [15:0] m_disp;
  logic        m_int;
  int          m_k;        // edges since reset

  typedef struct {
    logic        dv;
    logic [15:0] dd;
    logic [15:0] exp_disp;
    logic [15:0] exp_status;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic dv, input logic [15:0] dd,
                              input logic [15:0] ed, input logic [15:0] es);
    vec_t v;
    v.dv = dv; v.dd = dd; v.exp_disp = ed; v.exp_status = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 16'h0000; m_ctrl = 3'b011; m_pend = 1'b0; m_prev = 1'b0;
    m_mode = 0; m_remain = 0; m_dbgv = 16'h0000;
    m_disp = 16'h0000; m_int = 1'b0; m_k = 0;
  endtask

  function automatic logic m_ready();
    return m_ctrl[1] && !m_pend && (m_mode != 2);
  endfunction

  function automatic logic [15:0] m_rdata(input logic [1:0] a);
    logic [15:0] r;
    case (a)
      2'd0:    r = m_data;
      2'd1:    r = {13'b0, m_ctrl};
      2'd2:    r = {13'b0, 2'(m_mode), m_pend};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic logic m_scan();
    return ((m_k / SCAN_DIV) % 2) == 1;
  endfunction

  // Advance the model by one edge using the currently applied inputs
  task automatic model_step();
    logic [15:0] n_disp;
    logic        n_int;
    logic        n_pend;
    int          n_mode;
    int          n_remain;
    logic [15:0] n_dbgv;
    logic        rdy;
    if (reset) begin
      model_reset();
      return;
    end
    rdy    = m_ready();
    n_disp = m_disp;
    n_int  = 1'b0;
    if (m_mode == 0)      n_disp = m_data;
    else if (m_mode == 1) n_disp = m_dbgv;
    else                  n_int  = 1'b1;

    n_pend = m_pend;
    if (cpu_we && cpu_addr == 2'd2 && cpu_wdata[0]) n_pend = 1'b0;
    if (irq_in && !m_prev && m_ctrl[0])             n_pend = 1'b1;

    n_mode = m_mode; n_remain = m_remain; n_dbgv = m_dbgv;
    if (m_pend) n_mode = 2;
    else if (m_mode == 2) n_mode = 0;
    else if (dbg_valid && rdy) begin
      n_dbgv = dbg_data; n_remain = HOLD; n_mode = 1;
    end else if (m_mode == 1) begin
      if (!m_ctrl[1]) n_mode = 0;
      else begin
        n_remain--;
        if (n_remain == 0) n_mode = 0;
      end
    end

    if (cpu_we && cpu_addr == 2'd0) m_data = cpu_wdata;
    if (cpu_we && cpu_addr == 2'd1) m_ctrl = cpu_wdata[2:0];
    m_prev = irq_in; m_k++;
    m_disp = n_disp; m_int = n_int; m_pend = n_pend;
    m_mode = n_mode; m_remain = n_remain; m_dbgv = n_dbgv;
  endtask

  task automatic drive(input logic we, input logic [1:0] a, input logic [15:0] wd,
                       input logic irq, input logic dv, input logic [15:0] dd);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; irq_in = irq;
    dbg_valid = dv; dbg_data = dd;
  endtask

  // One clock: check combinational outputs, clock, check registered outputs
  task automatic cycle();
    #1;
    chk("rdata", cpu_rdata, m_rdata(cpu_addr));
    chk("dbg_ready", 16'(dbg_ready), 16'(m_ready()));
    model_step();
    @(posedge clk);
    #1;
    chk("disp_data", disp_data, m_disp);
    chk("disp_int", 16'(disp_interrupt), 16'(m_int));
    chk("scan_clk", 16'(scan_clk), 16'(m_scan()));
  endtask

  initial begin
    // Directed debug hold and restart vectors, starting in CPU with DATA=1234
    tbl[0] = mk(1'b1, 16'hBEEF, 16'h1234, 16'h0002);
    for (int i = 1; i <= 7; i++) tbl[i] = mk(1'b0, 16'h0000, 16'hBEEF, 16'h0002);
    tbl[8] = mk(1'b0, 16'h0000, 16'hBEEF, 16'h0000);
    tbl[9] = mk(1'b0, 16'h0000, 16'h1234, 16'h0000);
    tbl[10] = mk(1'b1, 16'hBEEF, 16'h1234, 16'h0002);
    for (int i = 11; i <= 14; i++) tbl[i] = mk(1'b0, 16'h0000, 16'hBEEF, 16'h0002);
    tbl[15] = mk(1'b1, 16'hCAFE, 16'hBEEF, 16'h0002);
    for (int i = 16; i <= 22; i++) tbl[i] = mk(1'b0, 16'h0000, 16'hCAFE, 16'h0002);
    tbl[23] = mk(1'b0, 16'h0000, 16'hCAFE, 16'h0000);
    tbl[24] = mk(1'b0, 16'h0000, 16'h1234, 16'h0000);

    reset = 1'b1;
    drive(1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_disp", disp_data, 16'h0000);
    chk("rst_int", 16'(disp_interrupt), 16'h0000);
    chk("rst_scan", 16'(scan_clk), 16'h0000);
    chk("rst_ctrl", cpu_rdata, 16'h0003);

    // Idle run: scan clock and reset display
    reset = 1'b0;
    for (int i = 0; i < 32; i++) cycle();
    chk("idle_ctrl", cpu_rdata, 16'h0003);
    chk("idle_disp", disp_data, 16'h0000);

    // CPU DATA write and one-edge display latency
    drive(1'b1, 2'd0, 16'h1234, 1'b0, 1'b0, 16'h0000);
    cycle();
    chk("wr_rdata", cpu_rdata, 16'h1234);
    chk("wr_disp_old", disp_data, 16'h0000);
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cycle();
    chk("wr_disp_new", disp_data, 16'h1234);
    chk("wr_ready", 16'(dbg_ready), 16'h0001);

    // Table-driven debug hold / restart
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 2'd2, 16'h0000, 1'b0, tbl[i].dv, tbl[i].dd);
      cycle();
      chk($sformatf("tbl%0d_disp", i), disp_data, tbl[i].exp_disp);
      chk($sformatf("tbl%0d_status", i), cpu_rdata, tbl[i].exp_status);
    end

    // Interrupt during a debug hold
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cycle(); cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000);
    cycle();
    chk("irq_ready", 16'(dbg_ready), 16'h0000);
    chk("irq_status_pend", cpu_rdata, 16'h0003);
    cycle();
    chk("irq_status_state", cpu_rdata, 16'h0005);
    chk("irq_int_lat", 16'(disp_interrupt), 16'h0000);
    cycle();
    chk("irq_int", 16'(disp_interrupt), 16'h0001);
    chk("irq_hold_digits", disp_data, 16'hBEEF);
    drive(1'b1, 2'd2, 16'h0001, 1'b1, 1'b0, 16'h0000);
    cycle();
    chk("w1c_status", cpu_rdata, 16'h0004);
    drive(1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000);
    cycle();
    chk("w1c_cpu", cpu_rdata, 16'h0000);
    cycle();
    chk("w1c_int", 16'(disp_interrupt), 16'h0000);
    chk("w1c_disp", disp_data, 16'h1234);

    // Rising edge racing a W1C clear: set wins
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000); cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000); cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000); cycle();
    drive(1'b1, 2'd2, 16'h0001, 1'b1, 1'b0, 16'h0000); cycle();
    chk("race_pend", cpu_rdata & 16'h0001, 16'h0001);
    cycle();
    chk("race_cleared", cpu_rdata & 16'h0001, 16'h0000);
    drive(1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000);
    cycle(); cycle();
    chk("race_back_cpu", cpu_rdata, 16'h0000);

    // irq_en=0 masks new edges
    drive(1'b1, 2'd1, 16'h0002, 1'b0, 1'b0, 16'h0000); cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000); cycle();
    chk("mask_pend", cpu_rdata, 16'h0000);
    cycle();
    chk("mask_int", 16'(disp_interrupt), 16'h0000);
    drive(1'b1, 2'd1, 16'h0003, 1'b0, 1'b0, 16'h0000); cycle();

    // Reset in the middle of a debug hold
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 16'hBEEF); cycle();
    drive(1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000); cycle(); cycle();
    chk("pre_rst_disp", disp_data, 16'hBEEF);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_disp", disp_data, 16'h0000);
    chk("mid_rst_scan", 16'(scan_clk), 16'h0000);
    cpu_addr = 2'd0; #1;
    chk("mid_rst_data", cpu_rdata, 16'h0000);
    cpu_addr = 2'd1; #1;
    chk("mid_rst_ctrl", cpu_rdata, 16'h0003);
    cpu_addr = 2'd2; #1;
    chk("mid_rst_status", cpu_rdata, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  a;
      logic [15:0] wd;
      reset = ($urandom_range(0, 249) == 0);
      a     = 2'($urandom_range(0, 3));
      wd    = 16'($urandom);
      if (a == 2'd1 && $urandom_range(0, 3) != 0) wd = 16'h0003;
      drive(($urandom_range(0, 7) == 0), a, wd,
            ($urandom_range(0, 9) == 0) ? ~irq_in : irq_in,
            ($urandom_range(0, 5) == 0), 16'($urandom));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
